// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision divider front end:
// FSM state encoding, out_flags bit positions and IEEE-754 constants.
package fp_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLASSIFY = 3'd1,
    ST_BYPASS   = 3'd2,
    ST_WAIT     = 3'd3,
    ST_HOLD     = 3'd4
  } state_e;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIVZERO   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

endpackage

// File: rtl/fp_div_fe_fifo.sv
// Operand FIFO: power-of-two depth, wrap-around read/write pointers plus an
// occupancy count. Pushes while full and pops while empty are ignored.
module fp_div_fe_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fp_div_frontend.sv
// Front end for a multi-cycle FP32 divider core: queues operand pairs, runs one
// op at a time, and optionally short-circuits special cases (FP_DIV_FE_BYPASS_EN).
module fp_div_frontend
  import fp_div_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int DIV_LATENCY = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_c,
  output logic [3:0]  out_flags,
  output logic [2:0]  dbg_state
);

  localparam int CW = $clog2(DIV_LATENCY + 2);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0]    div_a_q, div_a_d, div_b_q, div_b_d;
  logic [31:0]    out_c_q, out_c_d;
  logic [3:0]     out_flags_q, out_flags_d;

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [63:0]    fifo_head;

  logic [31:0]    a_fl, b_fl, byp_c;
  logic [3:0]     byp_flags;
  logic           byp_hit;

  // Both sides use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid-side data must hold until then.
  assign in_ready  = rst & ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  assign out_valid = (state_q == ST_HOLD);
  assign out_c     = out_c_q;
  assign out_flags = out_flags_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign dbg_state = state_q;

  fp_div_fe_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({in_a, in_b}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef FP_DIV_FE_BYPASS_EN
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, res_sign;
  logic [9:0] exp_est;

  always_comb begin
    // Denormals are flushed to signed zero before any classification.
    a_fl      = (op_a_q[30:23] == 8'd0) ? {op_a_q[31], 31'd0} : op_a_q;
    b_fl      = (op_b_q[30:23] == 8'd0) ? {op_b_q[31], 31'd0} : op_b_q;
    res_sign  = op_a_q[31] ^ op_b_q[31];
    a_nan     = (a_fl[30:23] == 8'(EXP_MAX)) && (a_fl[22:0] != 23'd0);
    b_nan     = (b_fl[30:23] == 8'(EXP_MAX)) && (b_fl[22:0] != 23'd0);
    a_inf     = (a_fl[30:23] == 8'(EXP_MAX)) && (a_fl[22:0] == 23'd0);
    b_inf     = (b_fl[30:23] == 8'(EXP_MAX)) && (b_fl[22:0] == 23'd0);
    a_zero    = (a_fl[30:0] == 31'd0);
    b_zero    = (b_fl[30:0] == 31'd0);
    exp_est   = {2'b00, a_fl[30:23]} - {2'b00, b_fl[30:23]} + 10'(EXP_BIAS)
              - {9'd0, (a_fl[22:0] < b_fl[22:0])};
    byp_hit   = 1'b1;
    byp_c     = '0;
    byp_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      byp_c                   = QNAN;
      byp_flags[FLAG_INVALID] = 1'b1;
    end else if (b_zero) begin
      byp_c                   = {res_sign, 8'hFF, 23'd0};
      byp_flags[FLAG_DIVZERO] = 1'b1;
    end else if (a_inf) begin
      byp_c = {res_sign, 8'hFF, 23'd0};
    end else if (b_inf || a_zero) begin
      byp_c = {res_sign, 31'd0};
    end else if ($signed(exp_est) >= 10'sd255) begin
      byp_c                    = {res_sign, 8'hFF, 23'd0};
      byp_flags[FLAG_OVERFLOW] = 1'b1;
    end else if ($signed(exp_est) <= 10'sd0) begin
      byp_c                     = {res_sign, 31'd0};
      byp_flags[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      byp_hit = 1'b0;
    end
  end
`else
  always_comb begin
    a_fl      = op_a_q;
    b_fl      = op_b_q;
    byp_hit   = 1'b0;
    byp_c     = '0;
    byp_flags = '0;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    out_c_d     = out_c_q;
    out_flags_d = out_flags_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_a_d   = fifo_head[63:32];
          op_b_d   = fifo_head[31:0];
          state_d  = ST_CLASSIFY;
        end
      end
      ST_CLASSIFY: begin
        if (byp_hit) begin
          state_d = ST_BYPASS;
        end else begin
          div_a_d = a_fl;
          div_b_d = b_fl;
          cnt_d   = CW'(DIV_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_BYPASS: begin
        out_c_d     = byp_c;
        out_flags_d = byp_flags;
        state_d     = ST_HOLD;
      end
      ST_WAIT: begin
        // The core output is only meaningful once the countdown expires.
        if (cnt_q == '0) begin
          out_c_d     = div_c;
          out_flags_d = '0;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      out_c_q     <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      out_c_q     <= out_c_d;
      out_flags_q <= out_flags_d;
    end
  end

endmodule

// File: doc/fp_div_frontend.md
FP_DIV_FRONTEND -- requirements
Module: fp_div_frontend

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning operand FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DIV_LATENCY, default 10, meaning clk cycles the divider core needs, with its operands held stable, before its result is valid.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  operand pair accepted when in_valid & in_ready.
REQ-007 in_a  input  32  IEEE-754 single dividend.
REQ-008 in_b  input  32  IEEE-754 single divisor.
REQ-009 div_a  output  32  dividend to divider core.
REQ-010 div_b  output  32  divisor to divider core.
REQ-011 div_c  input  32  quotient from divider core.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  result consumed when out_valid & out_ready.
REQ-014 out_c  output  32  quotient.
REQ-015 out_flags  output  4  {invalid, divzero, overflow, underflow}, bit 3 = invalid.

Function
REQ-016 SHALL buffer accepted operand pairs in a FIFO_DEPTH-entry FIFO; in_ready = FIFO not full; push when full and pop when empty SHALL be impossible; simultaneous push and pop SHALL keep the count unchanged.
REQ-017 SHALL run FSM IDLE -> CLASSIFY -> (BYPASS | WAIT) -> HOLD -> IDLE, with at most one operation outstanding.
REQ-018 IDLE: if FIFO non-empty, pop head into op registers and go to CLASSIFY.
REQ-019 CLASSIFY: flush denormal operands to signed zero; select bypass per REQ-020/021; otherwise register op into div_a/div_b, load counter = DIV_LATENCY, go to WAIT.
REQ-020 Bypass priority: NaN operand or 0/0 or inf/inf -> 0x7FC00000, invalid; B zero -> signed inf, divzero; A inf -> signed inf; B inf or A zero -> signed zero; no flags for the last two.
REQ-021 Range check on 10-bit signed e = eA - eB + 127 - (mA < mB): e >= 255 -> signed inf, overflow; e <= 0 -> signed zero, underflow.
REQ-022 Result sign SHALL be A[31] ^ B[31] for every result except NaN.
REQ-023 WAIT: decrement counter each cycle; div_a/div_b SHALL stay constant; at count 0 capture div_c into out_c, flags 0, go to HOLD.
REQ-024 BYPASS: load out_c/out_flags from REQ-020/021 result, go to HOLD; div_a/div_b unchanged.
REQ-025 HOLD: out_valid = 1, out_c/out_flags stable until out_ready; on handshake go to IDLE; a FIFO pop SHALL occur no earlier than the following cycle.
REQ-026 Latency, idle block and empty FIFO: core path out_valid asserts DIV_LATENCY+3 cycles after acceptance; bypass path 3 cycles.
REQ-027 div_c SHALL be sampled only at WAIT count 0; values at other times are don't-care (the core may float them).

Reset
REQ-028 On rst = 0: FSM IDLE, FIFO empty, counter 0, out_valid 0, out_c 0, out_flags 0, div_a 0, div_b 0; in_ready SHALL be 0 during reset.
REQ-029 Reset mid-operation SHALL discard the in-flight op and all FIFO contents, with no output.

Configuration
REQ-030 Macro FP_DIV_FE_BYPASS_EN defined: REQ-019 flush and REQ-020/021 bypass active.
REQ-031 Macro undefined: every op goes CLASSIFY -> WAIT through the core; out_flags tied 0; no classification logic synthesized.

Structure
REQ-032 Package fp_div_pkg SHALL hold the FSM state enum, flag bit indices, QNAN = 0x7FC00000, EXP_BIAS = 127 and EXP_MAX = 255.
REQ-033 The FIFO SHALL be sub-module fp_div_fe_fifo (parameter depth, width 64, wrap-around pointers plus count).

Verification
REQ-034 A=0x40C00000, B=0x40000000, core model returns 0x40400000 -> out_c 0x40400000, flags 0, out_valid at DIV_LATENCY+3.
REQ-035 A=0x3F800000, B=0x00000000 -> out_c 0x7F800000, flags 0b0100, 3-cycle latency, div_a/div_b unchanged.
REQ-036 A=0x00000000, B=0x80000000 -> 0x7FC00000, flags 0b1000; A=0x7F000000, B=0x3E800000 -> 0x7F800000, flags 0b0010.
REQ-037 out_ready held 0, 6 pairs offered back-to-back -> in_ready drops after 5 accepts (1 in HOLD + 4 queued); results emerge in order after out_ready = 1.
REQ-038 rst low during WAIT with 2 ops queued -> all outputs 0 next cycle; no stale result after rst returns high.
